axis_transmission_splitter: RTL and testbench

AXIS_TRANSMISSION_SPLITTER -- requirements
Module: axis_transmission_splitter

---
 rtl/axis_transmission_splitter_if.sv | 15 +
 rtl/axis_transmission_splitter.sv | 197 +++++++++++++++++++
 tb/tb_axis_transmission_splitter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_transmission_splitter_if.sv
// rtl/axis_transmission_splitter_if.sv - AXI-Stream bundle for the splitter source stream and its four lanes
interface axis_transmission_splitter_if #(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128
);
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic                     tvalid;
  logic                     tlast;
  logic                     tready;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_transmission_splitter.sv
// rtl/axis_transmission_splitter.sv - round-robin AXI-Stream splitter padding every packet to whole 4-lane groups
// Defining AXIS_SPLITTER_STATS_EN adds the 32-bit splitter_pkt_count output.

module axis_transmission_splitter_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         nearly_full
);
  logic [W-1:0] mem_q [16];
  logic [3:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [4:0]   count_q, count_d;
  logic         do_wr, do_rd;

  always_comb begin
    do_wr    = wr_en && (count_q != 5'd16);
    do_rd    = rd_en && (count_q != 5'd0);
    wr_ptr_d = wr_ptr_q + {3'b000, do_wr};
    rd_ptr_d = rd_ptr_q + {3'b000, do_rd};
    count_d  = count_q + {4'b0000, do_wr} - {4'b0000, do_rd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 4'd0;
      rd_ptr_q <= 4'd0;
      count_q  <= 5'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Head is forced to zero while empty so idle lanes present all-zero fields.
  assign empty       = (count_q == 5'd0);
  assign nearly_full = (count_q >= 5'd15);
  assign rd_data     = empty ? '0 : mem_q[rd_ptr_q];
endmodule

module axis_transmission_splitter #(
  parameter int TDATA_WIDTH = 256,
  parameter int TUSER_WIDTH = 128
) (
  input  logic                                axis_aclk,
  input  logic                                axis_resetn,
  axis_transmission_splitter_if.slave         axis_input,
  axis_transmission_splitter_if.master        axis_output_0,
  axis_transmission_splitter_if.master        axis_output_1,
  axis_transmission_splitter_if.master        axis_output_2,
  axis_transmission_splitter_if.master        axis_output_3
`ifdef AXIS_SPLITTER_STATS_EN
  ,
  output logic [31:0]                         splitter_pkt_count
`endif
);
  localparam int KW = TDATA_WIDTH / 8;
  localparam int BW = 1 + TUSER_WIDTH + KW + TDATA_WIDTH;

  typedef enum logic {DISTRIBUTE, PAD} state_t;

  logic [BW-1:0] in_data;
  logic          in_empty, in_nearly_full, in_pop, in_null, in_last;
  logic [BW-1:0] out_data [4];
  logic [3:0]    out_empty, out_nearly_full, out_ready;

  state_t        state_q, state_d;
  logic [1:0]    lane_q, lane_d;
  logic          wr_en_q, wr_en_d;
  logic [1:0]    wr_lane_q, wr_lane_d;
  logic [BW-1:0] wr_data_q, wr_data_d;
`ifdef AXIS_SPLITTER_STATS_EN
  logic [31:0]   pkt_count_q, pkt_count_d;
`endif

  axis_transmission_splitter_fifo #(.W(BW)) u_in_fifo (
    .clk         (axis_aclk),
    .rst_n       (axis_resetn),
    .wr_en       (axis_input.tvalid && !in_nearly_full),
    .wr_data     ({axis_input.tlast, axis_input.tuser, axis_input.tkeep, axis_input.tdata}),
    .rd_en       (in_pop),
    .rd_data     (in_data),
    .empty       (in_empty),
    .nearly_full (in_nearly_full)
  );

  assign axis_input.tready = ~in_nearly_full;
  assign in_last           = in_data[BW-1];
  assign in_null           = (in_data[TDATA_WIDTH +: KW] == '0);

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    wr_en_d   = 1'b0;
    wr_lane_d = wr_lane_q;
    wr_data_d = wr_data_q;
    in_pop    = 1'b0;
`ifdef AXIS_SPLITTER_STATS_EN
    pkt_count_d = pkt_count_q;
`endif
    case (state_q)
      DISTRIBUTE: begin
        // Null beats are dropped even when the target lane is backed up.
        if (!in_empty && in_null) begin
          in_pop = 1'b1;
        end else if (!in_empty && !out_nearly_full[lane_q]) begin
          in_pop    = 1'b1;
          wr_en_d   = 1'b1;
          wr_lane_d = lane_q;
          wr_data_d = in_data;
          lane_d    = lane_q + 2'd1;
          if (in_last && lane_q != 2'd3) begin
            state_d = PAD;
          end
`ifdef AXIS_SPLITTER_STATS_EN
          if (in_last) begin
            pkt_count_d = pkt_count_q + 32'd1;
          end
`endif
        end
      end
      PAD: begin
        if (!out_nearly_full[lane_q]) begin
          wr_en_d   = 1'b1;
          wr_lane_d = lane_q;
          wr_data_d = {1'b1, {(BW-1){1'b0}}};
          lane_d    = lane_q + 2'd1;
          if (lane_q == 2'd3) begin
            state_d = DISTRIBUTE;
          end
        end
      end
      default: state_d = DISTRIBUTE;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q   <= DISTRIBUTE;
      lane_q    <= 2'd0;
      wr_en_q   <= 1'b0;
      wr_lane_q <= 2'd0;
      wr_data_q <= '0;
`ifdef AXIS_SPLITTER_STATS_EN
      pkt_count_q <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      wr_en_q   <= wr_en_d;
      wr_lane_q <= wr_lane_d;
      wr_data_q <= wr_data_d;
`ifdef AXIS_SPLITTER_STATS_EN
      pkt_count_q <= pkt_count_d;
`endif
    end
  end

`ifdef AXIS_SPLITTER_STATS_EN
  assign splitter_pkt_count = pkt_count_q;
`endif

  for (genvar i = 0; i < 4; i++) begin : g_lane
    axis_transmission_splitter_fifo #(.W(BW)) u_out_fifo (
      .clk         (axis_aclk),
      .rst_n       (axis_resetn),
      .wr_en       (wr_en_q && (wr_lane_q == 2'(i))),
      .wr_data     (wr_data_q),
      .rd_en       (out_ready[i]),
      .rd_data     (out_data[i]),
      .empty       (out_empty[i]),
      .nearly_full (out_nearly_full[i])
    );
  end

  assign {axis_output_0.tlast, axis_output_0.tuser, axis_output_0.tkeep, axis_output_0.tdata} = out_data[0];
  assign {axis_output_1.tlast, axis_output_1.tuser, axis_output_1.tkeep, axis_output_1.tdata} = out_data[1];
  assign {axis_output_2.tlast, axis_output_2.tuser, axis_output_2.tkeep, axis_output_2.tdata} = out_data[2];
  assign {axis_output_3.tlast, axis_output_3.tuser, axis_output_3.tkeep, axis_output_3.tdata} = out_data[3];
  assign axis_output_0.tvalid = ~out_empty[0];
  assign axis_output_1.tvalid = ~out_empty[1];
  assign axis_output_2.tvalid = ~out_empty[2];
  assign axis_output_3.tvalid = ~out_empty[3];
  assign out_ready = {axis_output_3.tready, axis_output_2.tready, axis_output_1.tready, axis_output_0.tready};
endmodule

// File: tb/tb_axis_transmission_splitter.sv
// tb/tb_axis_transmission_splitter.sv - randomized scoreboard bench for axis_transmission_splitter
module tb_axis_transmission_splitter;
  localparam int DW = 64;
  localparam int UW = 16;
  localparam int KW = DW / 8;

  typedef struct packed {
    logic          last;
    logic [UW-1:0] user;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  localparam beat_t PAD_BEAT = {1'b1, {UW{1'b0}}, {KW{1'b0}}, {DW{1'b0}}};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_transmission_splitter_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) in_if ();
  axis_transmission_splitter_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) o0 ();
  axis_transmission_splitter_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) o1 ();
  axis_transmission_splitter_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) o2 ();
  axis_transmission_splitter_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) o3 ();
`ifdef AXIS_SPLITTER_STATS_EN
  logic [31:0] pkt_count;
`endif

  axis_transmission_splitter #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) dut (
    .axis_aclk     (clk),
    .axis_resetn   (rst_n),
    .axis_input    (in_if),
    .axis_output_0 (o0),
    .axis_output_1 (o1),
    .axis_output_2 (o2),
    .axis_output_3 (o3)
`ifdef AXIS_SPLITTER_STATS_EN
    ,
    .splitter_pkt_count (pkt_count)
`endif
  );

  logic [3:0] o_valid;
  logic [3:0] o_ready = 4'hF;
  beat_t      o_beat [4];
  beat_t      in_beat;
  assign o_valid = {o3.tvalid, o2.tvalid, o1.tvalid, o0.tvalid};
  assign o_beat[0] = {o0.tlast, o0.tuser, o0.tkeep, o0.tdata};
  assign o_beat[1] = {o1.tlast, o1.tuser, o1.tkeep, o1.tdata};
  assign o_beat[2] = {o2.tlast, o2.tuser, o2.tkeep, o2.tdata};
  assign o_beat[3] = {o3.tlast, o3.tuser, o3.tkeep, o3.tdata};
  assign in_beat   = {in_if.tlast, in_if.tuser, in_if.tkeep, in_if.tdata};
  assign o0.tready = o_ready[0];
  assign o1.tready = o_ready[1];
  assign o2.tready = o_ready[2];
  assign o3.tready = o_ready[3];

  int    total = 0;
  int    bad = 0;
  beat_t exp_q [4][$];
  beat_t got_q [4][$];
  int    pkt_pos = 0;
  int    model_pkts = 0;
  bit    rand_rdy = 1'b0;
  bit [3:0] stall_mask = 4'b0000;
  bit    saw_in_stall = 1'b0;
  bit    abort = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Packet-level reference: non-null beats fill lanes 0..3 in turn, tlast closes the group with pads.
  function automatic void model_accept(input beat_t b);
    if (b.keep == '0) return;
    exp_q[pkt_pos % 4].push_back(b);
    pkt_pos++;
    if (b.last) begin
      model_pkts++;
      while (pkt_pos % 4 != 0) begin
        exp_q[pkt_pos % 4].push_back(PAD_BEAT);
        pkt_pos++;
      end
      pkt_pos = 0;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    pkt_pos = 0;
    model_pkts = 0;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < 4; i++) begin
          if (o_valid[i]) begin
            if (exp_q[i].size() == 0) begin
              total++;
              bad++;
              $display("FAIL lane%0d_unexpected actual=%0h required=none", i, o_beat[i]);
            end else begin
              chk($sformatf("lane%0d_beat", i), o_beat[i], exp_q[i][0]);
              if (o_ready[i]) void'(exp_q[i].pop_front());
            end
            if (o_ready[i]) got_q[i].push_back(o_beat[i]);
          end
        end
        if (in_if.tvalid && in_if.tready) model_accept(in_beat);
        if (in_if.tvalid && !in_if.tready) saw_in_stall = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++)
        o_ready[i] = !stall_mask[i] && (rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input int gap);
    if (abort) return;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_if.tdata  = d;
    in_if.tkeep  = k;
    in_if.tuser  = UW'($urandom);
    in_if.tlast  = l;
    in_if.tvalid = 1'b1;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (in_if.tready) break;
      if (n > 1000) begin
        total++;
        bad++;
        abort = 1'b1;
        $display("FAIL send_timeout actual=stalled required=accepted");
        break;
      end
    end
    @(posedge clk);
    #1;
    in_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    rand_rdy   = 1'b0;
    stall_mask = 4'b0000;
    done = 1'b0;
    for (int n = 0; n < 2000 && !done; n++) begin
      @(negedge clk);
      done = (exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) == 0;
    end
    repeat (4) @(negedge clk);
    chk("drain_model_empty", exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size(), 0);
    chk("drain_idle_valid", o_valid, 4'b0000);
`ifdef AXIS_SPLITTER_STATS_EN
    chk("pkt_count", pkt_count, model_pkts);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 4; i++) got_q[i].delete();
  endtask

  task automatic expect_lane(input int lane, input int idx, input logic [DW-1:0] d, input bit pad, input bit last);
    beat_t g;
    g = '1;
    if (got_q[lane].size() > idx) g = got_q[lane][idx];
    chk($sformatf("lane%0d_item%0d", lane, idx), {g.last, g.keep != '0, g.data}, {last, !pad, d});
  endtask

  task automatic expect_counts(input int n);
    for (int i = 0; i < 4; i++) chk($sformatf("lane%0d_count", i), got_q[i].size(), n);
  endtask

  task automatic expect_a_packet(input logic [DW-1:0] base);
    expect_counts(1);
    for (int i = 0; i < 4; i++) expect_lane(i, 0, base + DW'(i), 1'b0, i == 3);
  endtask

  initial begin
    in_if.tvalid = 1'b0;
    in_if.tdata  = '0;
    in_if.tkeep  = '0;
    in_if.tuser  = '0;
    in_if.tlast  = 1'b0;
    @(negedge clk);
    chk("reset_valid", o_valid, 4'b0000);
    chk("reset_lane0_data", o_beat[0], '0);
    @(negedge clk);
    chk("reset_tready", in_if.tready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // first-beat latency: handshake cycle 0, lane 0 valid in cycle 3
    in_if.tdata = 64'h11; in_if.tkeep = '1; in_if.tuser = '0; in_if.tlast = 1'b1; in_if.tvalid = 1'b1;
    @(negedge clk);
    chk("lat_accept", in_if.tready, 1'b1);
    @(posedge clk);
    #1;
    in_if.tvalid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1", o_valid[0], 1'b0);
    @(negedge clk);
    chk("lat_cycle2", o_valid[0], 1'b0);
    @(negedge clk);
    chk("lat_cycle3", o_valid[0], 1'b1);
    drain();

    clear_logs();
    for (int i = 0; i < 4; i++) send(64'hA0 + DW'(i), '1, i == 3, 0);
    drain();
    expect_a_packet(64'hA0);

    clear_logs();
    send(64'hB0, '1, 1'b0, 0);
    send(64'hB1, '1, 1'b1, 1);
    send(64'hC0, '1, 1'b1, 0);
    drain();
    expect_counts(2);
    expect_lane(0, 0, 64'hB0, 1'b0, 1'b0);
    expect_lane(1, 0, 64'hB1, 1'b0, 1'b1);
    expect_lane(2, 0, 64'h0, 1'b1, 1'b1);
    expect_lane(3, 0, 64'h0, 1'b1, 1'b1);
    expect_lane(0, 1, 64'hC0, 1'b0, 1'b1);
    for (int i = 1; i < 4; i++) expect_lane(i, 1, 64'h0, 1'b1, 1'b1);

    clear_logs();
    for (int i = 0; i < 5; i++) send(64'hE0 + DW'(i), '1, i == 4, 0);
    drain();
    expect_counts(2);
    for (int i = 0; i < 4; i++) expect_lane(i, 0, 64'hE0 + DW'(i), 1'b0, 1'b0);
    expect_lane(0, 1, 64'hE4, 1'b0, 1'b1);
    for (int i = 1; i < 4; i++) expect_lane(i, 1, 64'h0, 1'b1, 1'b1);

    clear_logs();
    send(64'hA0, '1, 1'b0, 0);
    send(64'hA1, '1, 1'b0, 0);
    send(64'hFF, '0, 1'b1, 0);
    send(64'hA2, '1, 1'b0, 0);
    send(64'hA3, '1, 1'b1, 0);
    drain();
    expect_a_packet(64'hA0);

    rand_rdy = 1'b1;
    for (int p = 0; p < 150; p++) begin
      int len;
      logic [KW-1:0] k;
      len = $urandom_range(1, 9);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 7) == 0) send({$urandom, $urandom}, '0, 1'($urandom), $urandom_range(0, 2));
        k = KW'($urandom);
        if (k == '0) k = 1;
        send({$urandom, $urandom}, k, b == len - 1, $urandom_range(0, 2));
      end
    end
    drain();

    // lane 2 held off long enough for backpressure to reach the source
    clear_logs();
    stall_mask = 4'b0100;
    saw_in_stall = 1'b0;
    fork
      begin
        for (int p = 0; p < 20; p++)
          for (int b = 0; b < 4; b++) send(64'h1000 + DW'(p * 4 + b), '1, b == 3, 0);
      end
      begin
        for (int n = 0; n < 2000 && !saw_in_stall; n++) @(negedge clk);
        repeat (20) @(posedge clk);
        #1;
        stall_mask = 4'b0000;
      end
    join
    chk("stall_tready_fell", saw_in_stall, 1'b1);
    drain();
    expect_counts(20);
    expect_lane(2, 19, 64'h1000 + 64'd78, 1'b0, 1'b0);
    expect_lane(3, 19, 64'h1000 + 64'd79, 1'b0, 1'b1);

    send(64'hF0, '1, 1'b0, 0);
    send(64'hF1, '1, 1'b0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("midrst_valid", o_valid, 4'b0000);
      chk("midrst_lane0_data", o_beat[0], '0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_logs();
    for (int i = 0; i < 4; i++) send(64'hD0 + DW'(i), '1, i == 3, 0);
    drain();
    expect_a_packet(64'hD0);
`ifdef AXIS_SPLITTER_STATS_EN
    chk("pkt_count_after_reset", pkt_count, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
